// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified I/D memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    I_DROP = 2'd3
  } arb_state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter that flags the cycle in which a memory transaction hits its time limit.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int                CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Expiry fires during the TIMEOUT-th busy cycle so the abort lands on that edge.
  assign o_expire = i_en & (r_cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch (I) and data (D) ports onto one single-port memory.
// Optional round-robin arbitration when ARB_RR_EN is defined; default is fixed D-over-I.
//
// state  | meaning
// IDLE   | no transaction
// I_BUSY | fetch in flight
// D_BUSY | data access in flight
// I_DROP | fetch in flight, result discarded
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_i,
  output logic              stall_d,
  output logic              bus_err
);

  arb_state_t        r_state;
  logic              w_busy;
  logic              w_i_elig;
  logic              w_d_elig;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_grant;
  logic              w_expire;
  logic              w_done;
  logic              w_i_keep;
  logic [DATA_W-1:0] w_done_data;

  assign stall_i = i_req & ~i_ack;
  assign stall_d = d_req & ~d_ack;

  // A port that is being acked this cycle is still holding its old request.
  assign w_d_elig = d_req & ~d_ack;
  assign w_i_elig = i_req & ~i_abort & ~i_ack;

`ifdef ARB_RR_EN
  logic r_ptr;

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (w_d_elig && w_i_elig) begin
      if (r_ptr == PORT_D) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_d = 1'b1;
      end
    end else begin
      w_grant_i = w_i_elig;
      w_grant_d = w_d_elig;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= PORT_D;
    end else if (!w_busy) begin
      if (w_grant_d) begin
        r_ptr <= PORT_D;
      end else if (w_grant_i) begin
        r_ptr <= PORT_I;
      end
    end
  end
`else
  // Data side wins: the M-stage instruction is older and blocks retirement.
  assign w_grant_d = w_d_elig;
  assign w_grant_i = w_i_elig & ~w_d_elig;
`endif

  assign w_busy  = (r_state != IDLE);
  assign w_grant = ~w_busy & (w_grant_i | w_grant_d);

  generate
    if (TIMEOUT > 0) begin : g_wdog
      arb_watchdog #(
        .TIMEOUT (TIMEOUT)
      ) u_wdog (
        .clk      (clk),
        .rst_n    (rst),
        .i_clr    (w_grant),
        .i_en     (w_busy),
        .o_expire (w_expire)
      );
    end else begin : g_no_wdog
      assign w_expire = 1'b0;
    end
  endgenerate

  // mem_ready takes precedence over a coincident expiry.
  assign w_done      = mem_ready | w_expire;
  assign w_done_data = mem_ready ? mem_rdata : '0;
  assign w_i_keep    = (r_state == I_BUSY) & ~i_abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      if (!w_busy) begin
        if (w_grant_d) begin
          r_state   <= D_BUSY;
          mem_req   <= 1'b1;
          mem_we    <= d_we;
          mem_addr  <= d_addr;
          mem_wdata <= d_wdata;
        end else if (w_grant_i) begin
          r_state   <= I_BUSY;
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= i_addr;
          mem_wdata <= '0;
        end
      end else if (w_done) begin
        r_state <= IDLE;
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        bus_err <= ~mem_ready;
        if (r_state == D_BUSY) begin
          d_ack   <= 1'b1;
          d_rdata <= w_done_data;
        end else if (w_i_keep) begin
          i_ack   <= 1'b1;
          i_rdata <= w_done_data;
        end
      end else if (r_state == I_BUSY && i_abort) begin
        r_state <= I_DROP;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_req = 1'b0, i_abort = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic          i_ack, d_ack, mem_req, mem_we, stall_i, stall_d, bus_err;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_i(stall_i), .stall_d(stall_d), .bus_err(bus_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0 = none, 1 = fetch, 2 = data.
  int          m_owner, m_age, m_last;
  bit          m_drop;
  logic        e_i_ack, e_d_ack, e_bus_err, e_mem_req, e_mem_we, e_d_rdata_ok;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_last = 2; m_drop = 0;
    e_i_ack = 0; e_d_ack = 0; e_bus_err = 0; e_mem_req = 0; e_mem_we = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_i_rdata = '0; e_d_rdata = '0; e_d_rdata_ok = 1;
  endtask

  task automatic model_step();
    bit d_ok, i_ok, killed;
    int win;
    logic [DW-1:0] data;
    if (!rst) begin
      model_reset();
      return;
    end
    d_ok = d_req && !e_d_ack;
    i_ok = i_req && !i_abort && !e_i_ack;
    e_i_ack = 0; e_d_ack = 0; e_bus_err = 0;
    if (m_owner == 0) begin
      win = 0;
      if (d_ok && i_ok) begin
`ifdef ARB_RR_EN
        win = (m_last == 2) ? 1 : 2;
`else
        win = 2;
`endif
      end else if (d_ok) win = 2;
      else if (i_ok) win = 1;
      if (win != 0) begin
        m_owner = win; m_drop = 0; m_age = 0; m_last = win; e_mem_req = 1;
        e_mem_we    = (win == 2) ? d_we : 1'b0;
        e_mem_addr  = (win == 2) ? d_addr : i_addr;
        e_mem_wdata = d_wdata;
      end
    end else begin
      m_age++;
      killed = m_drop || (m_owner == 1 && i_abort);
      if (mem_ready || (TO > 0 && m_age >= TO)) begin
        data = mem_ready ? mem_rdata : '0;
        e_bus_err = !mem_ready;
        if (m_owner == 2) begin
          e_d_ack = 1; e_d_rdata = data; e_d_rdata_ok = !e_mem_we;
        end else if (!killed) begin
          e_i_ack = 1; e_i_rdata = data;
        end
        m_owner = 0; e_mem_req = 0; e_mem_we = 0;
      end else if (m_owner == 1 && i_abort) begin
        m_drop = 1;
      end
    end
  endtask

  task automatic compare();
    check_val("i_ack", i_ack, e_i_ack);
    check_val("d_ack", d_ack, e_d_ack);
    check_val("bus_err", bus_err, e_bus_err);
    check_val("mem_req", mem_req, e_mem_req);
    check_val("i_rdata", i_rdata, e_i_rdata);
    check_val("stall_i", stall_i, i_req & ~e_i_ack);
    check_val("stall_d", stall_d, d_req & ~e_d_ack);
    if (e_d_rdata_ok) check_val("d_rdata", d_rdata, e_d_rdata);
    if (e_mem_req) begin
      check_val("mem_addr", mem_addr, e_mem_addr);
      check_val("mem_we", mem_we, e_mem_we);
      if (e_mem_we) check_val("mem_wdata", mem_wdata, e_mem_wdata);
    end
  endtask

  // Stimulus knobs: fixed_delay < 0 selects random memory latency.
  int fixed_delay = 0;
  int p_req = 0;
  int p_abort = 0;
  int cd = 0;
  bit prev_seen = 0;

  task automatic drive_step();
    if (e_i_ack) begin
      i_req  = ($urandom_range(0, 99) < p_req);
      i_addr = i_addr + 32'd4;
    end else if (!i_req && $urandom_range(0, 99) < p_req) begin
      i_req  = 1'b1;
      i_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (p_abort > 0) begin
      i_abort = ($urandom_range(0, 99) < p_abort);
      if (i_abort) i_addr = $urandom() & 32'hFFFF_FFFC;
    end
    if (e_d_ack) d_req = 1'b0;
    if (!d_req && !e_d_ack && $urandom_range(0, 99) < p_req) begin
      d_req   = 1'b1;
      d_we    = $urandom_range(0, 1);
      d_addr  = $urandom() & 32'hFFFF_FFFC;
      d_wdata = $urandom();
    end
    if (mem_req && !prev_seen) cd = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 5);
    prev_seen = mem_req;
    if (mem_req && cd == 0) mem_ready = 1'b1;
    else begin
      mem_ready = 1'b0;
      if (mem_req) cd--;
    end
    mem_rdata = $urandom();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      drive_step();
      tick();
    end
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;

    // single fetch straight out of reset
    fixed_delay = 0;
    i_req = 1'b1; i_addr = 32'h0040_0000;
    cycles(4);

    // store and fetch requested together
    fixed_delay = 1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0000; d_wdata = 32'hCAFE_F00D;
    i_req = 1'b1; i_addr = 32'h0040_0004;
    cycles(10);

    // fetch flushed while in flight
    fixed_delay = 3;
    i_req = 1'b1; i_addr = 32'h0040_0008;
    cycles(1);
    drive_step();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0; i_addr = 32'h0040_0100;
    cycles(10);

    // load that never completes
    fixed_delay = 100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0004;
    cycles(8);

    // reset while a data access is in flight
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
    cycles(2);
    #2 rst = 1'b0;
    #1 model_reset();
    check_val("async_mem_req", mem_req, e_mem_req);
    tick();
    cycles(2);
    rst = 1'b1;
    fixed_delay = 1;
    cycles(6);

    // randomized traffic
    fixed_delay = -1; p_req = 60; p_abort = 4;
    cycles(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
